tespar: RTL and testbench

Streaming TESPAR (Time Encoded Signal Processing And Recognition) encoder. It consumes one signed 8-bit sample per clock and splits the waveform into epochs, where an epoch is a run of samples of the same sign. Each epoch's duration D and shape S are mapped through a fixed codebook to a 5-bit symbol. The block sits after sample acquisition and feeds the symbol histogram and recognition stage with one `code` + `valid` pulse per completed epoch.

---
 rtl/tespar_pkg.sv | 65 ++++++
 rtl/tespar_codebook.sv | 32 +++
 rtl/tespar.sv | 112 +++++++++++
 tb/tb_tespar.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tespar_pkg.sv
// Shared widths, codebook bands and epoch state types for the TESPAR encoder.
package tespar_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned CODE_W   = 5;
  localparam int unsigned D_W      = 6;
  localparam int unsigned D_SAT    = 63;
  localparam int unsigned S_W      = 3;
  localparam int unsigned S_SAT    = 7;

  // Upper duration bound (inclusive) of each codebook band.
  localparam int unsigned D_BAND0_MAX = 3;
  localparam int unsigned D_BAND1_MAX = 5;
  localparam int unsigned D_BAND2_MAX = 7;
  localparam int unsigned D_BAND3_MAX = 10;
  localparam int unsigned D_BAND4_MAX = 13;
  localparam int unsigned D_BAND5_MAX = 18;
  localparam int unsigned D_BAND6_MAX = 23;

  // First code of each band; the shape count is added as an offset.
  localparam int unsigned CODE_BAND1 = 4;
  localparam int unsigned CODE_BAND2 = 6;
  localparam int unsigned CODE_BAND3 = 9;
  localparam int unsigned CODE_BAND4 = 12;
  localparam int unsigned CODE_BAND5 = 16;
  localparam int unsigned CODE_BAND6 = 20;
  localparam int unsigned CODE_BAND7 = 24;

  // Largest shape offset used by each band group.
  localparam int unsigned S_OFS_BAND1  = 1;
  localparam int unsigned S_OFS_BAND23 = 2;
  localparam int unsigned S_OFS_WIDE   = 3;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_RISE = 2'd1,
    DIR_FALL = 2'd2
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_e;

  typedef struct packed {
    logic           neg;
    logic [D_W-1:0] d;
    logic [S_W-1:0] s;
    dir_e           dir;
  } epoch_t;

  function automatic logic [D_W-1:0] d_inc(input logic [D_W-1:0] d);
    return (d == D_W'(D_SAT)) ? d : d + D_W'(1);
  endfunction

  function automatic logic [S_W-1:0] s_inc(input logic [S_W-1:0] s);
    return (s == S_W'(S_SAT)) ? s : s + S_W'(1);
  endfunction

  function automatic logic [S_W-1:0] s_clip(input logic [S_W-1:0] s,
                                            input int unsigned   lim);
    return (32'(s) > lim) ? S_W'(lim) : s;
  endfunction

endpackage

// File: rtl/tespar_codebook.sv
// Combinational mapping of epoch duration and shape to a TESPAR symbol.
module tespar_codebook
  import tespar_pkg::*;
(
  input  logic [D_W-1:0]    d,
  input  logic [S_W-1:0]    s,
  output logic [CODE_W-1:0] code_c
);

  // Short epochs ignore shape; longer bands add a clipped shape offset.
  always_comb begin
    code_c = '0;
    if (d <= D_W'(D_BAND0_MAX)) begin
      code_c = CODE_W'(d);
    end else if (d <= D_W'(D_BAND1_MAX)) begin
      code_c = CODE_W'(CODE_BAND1) + CODE_W'(s_clip(s, S_OFS_BAND1));
    end else if (d <= D_W'(D_BAND2_MAX)) begin
      code_c = CODE_W'(CODE_BAND2) + CODE_W'(s_clip(s, S_OFS_BAND23));
    end else if (d <= D_W'(D_BAND3_MAX)) begin
      code_c = CODE_W'(CODE_BAND3) + CODE_W'(s_clip(s, S_OFS_BAND23));
    end else if (d <= D_W'(D_BAND4_MAX)) begin
      code_c = CODE_W'(CODE_BAND4) + CODE_W'(s_clip(s, S_OFS_WIDE));
    end else if (d <= D_W'(D_BAND5_MAX)) begin
      code_c = CODE_W'(CODE_BAND5) + CODE_W'(s_clip(s, S_OFS_WIDE));
    end else if (d <= D_W'(D_BAND6_MAX)) begin
      code_c = CODE_W'(CODE_BAND6) + CODE_W'(s_clip(s, S_OFS_WIDE));
    end else begin
      code_c = CODE_W'(CODE_BAND7) + CODE_W'(s_clip(s, S_OFS_WIDE));
    end
  end

endmodule

// File: rtl/tespar.sv
// Streaming TESPAR encoder: splits samples into same-sign epochs and emits
// one codebook symbol per closed epoch.
module tespar
  import tespar_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic        [CODE_W-1:0]   code,
  output logic                       valid
);

  state_e              state_q;
  state_e              state_d;
  epoch_t              epoch_q;
  epoch_t              epoch_d;
  epoch_t              fresh_c;
  logic [SAMPLE_W-1:0] prev_q;
  logic [SAMPLE_W:0]   diff_c;
  logic                sign_c;
  logic                rise_c;
  logic                fall_c;
  logic                emit_c;
  logic [CODE_W-1:0]   cb_code_c;

  assign sign_c = din[SAMPLE_W-1];

  // Sign-extended difference; only consulted inside a same-sign epoch.
  assign diff_c = {din[SAMPLE_W-1], din} - {prev_q[SAMPLE_W-1], prev_q};
  assign rise_c = !diff_c[SAMPLE_W] && (diff_c != '0);
  assign fall_c = diff_c[SAMPLE_W];

  assign fresh_c.neg = sign_c;
  assign fresh_c.d   = D_W'(1);
  assign fresh_c.s   = '0;
  assign fresh_c.dir = DIR_NONE;

  tespar_codebook u_codebook (
    .d      (epoch_q.d),
    .s      (epoch_q.s),
    .code_c (cb_code_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Any sample taken while idle opens an epoch; it then stays open.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_OPEN;
      ST_OPEN: state_d = ST_OPEN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Epoch update and close decision for the sample presented this cycle.
  always_comb begin
    epoch_d = epoch_q;
    emit_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        epoch_d = fresh_c;
      end
      ST_OPEN: begin
        if (sign_c != epoch_q.neg) begin
          emit_c  = 1'b1;
          epoch_d = fresh_c;
        end else begin
          epoch_d.d = d_inc(epoch_q.d);
          // Positive epochs count minima, negative epochs count maxima.
          if (rise_c) begin
            if (!epoch_q.neg && (epoch_q.dir == DIR_FALL)) begin
              epoch_d.s = s_inc(epoch_q.s);
            end
            epoch_d.dir = DIR_RISE;
          end else if (fall_c) begin
            if (epoch_q.neg && (epoch_q.dir == DIR_RISE)) begin
              epoch_d.s = s_inc(epoch_q.s);
            end
            epoch_d.dir = DIR_FALL;
          end
        end
      end
      default: begin
        epoch_d = fresh_c;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epoch_q <= '0;
      prev_q  <= '0;
      code    <= '0;
      valid   <= 1'b0;
    end else begin
      epoch_q <= epoch_d;
      prev_q  <= din;
      valid   <= emit_c;
      if (emit_c) begin
        code <= cb_code_c;
      end
    end
  end

endmodule

// File: tb/tb_tespar.sv
// Bench for tespar: queue-based epoch model plus literal code lists.
module tb_tespar;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] din;
  logic [4:0]        code;
  logic              valid;

  always #5 clk = ~clk;

  tespar dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .code  (code),
    .valid (valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: samples of the open epoch and the expected outputs.
  int mq[$];
  bit m_open;
  int exp_code;
  bit exp_valid;
  int model_codes[$];
  int dut_codes[$];

  int ub[10]     = '{1, 2, 3, 5, 7, 10, 13, 18, 23, 63};
  int base[10]   = '{1, 2, 3, 4, 6, 9, 12, 16, 20, 24};
  int maxofs[10] = '{0, 0, 0, 1, 2, 2, 3, 3, 3, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int code_of(input int q[$]);
    int  d;
    int  s;
    int  last;
    bit  neg;
    bit  found;
    int  res;
    d = (q.size() > 63) ? 63 : q.size();
    s = 0;
    last = 0;
    neg = q[0] < 0;
    for (int i = 1; i < q.size(); i++) begin
      int df;
      df = q[i] - q[i-1];
      if (df > 0) begin
        if (!neg && last < 0) s++;
        last = 1;
      end else if (df < 0) begin
        if (neg && last > 0) s++;
        last = -1;
      end
    end
    if (s > 7) s = 7;
    found = 1'b0;
    res = 0;
    for (int b = 0; b < 10; b++) begin
      if (!found && d <= ub[b]) begin
        found = 1'b1;
        res = base[b] + ((s > maxofs[b]) ? maxofs[b] : s);
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_open    = 1'b0;
    exp_code  = 0;
    exp_valid = 1'b0;
  endtask

  // Present one sample and advance the model to the post-edge expectation.
  task automatic step(input int s);
    din = 8'(s);
    exp_valid = 1'b0;
    if (!m_open) begin
      mq.delete();
      mq.push_back(s);
      m_open = 1'b1;
    end else if ((s < 0) != (mq[0] < 0)) begin
      exp_valid = 1'b1;
      exp_code  = code_of(mq);
      model_codes.push_back(exp_code);
      mq.delete();
      mq.push_back(s);
    end else begin
      mq.push_back(s);
    end
  endtask

  task automatic apply(input int v[$]);
    @(negedge clk);
    reset = 1'b0;
    din   = '0;
    model_reset();
    model_codes.delete();
    dut_codes.delete();
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b1;
      step(v[i]);
    end
    repeat (3) begin
      @(negedge clk);
      step(v[v.size()-1]);
    end
    @(negedge clk);
  endtask

  task automatic check_codes(input string name, input int e[$]);
    chk({name, " dut count"}, 32'(dut_codes.size()), 32'(e.size()));
    chk({name, " model count"}, 32'(model_codes.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      if (i < dut_codes.size())   chk({name, " dut code"}, 32'(dut_codes[i]), 32'(e[i]));
      if (i < model_codes.size()) chk({name, " model code"}, 32'(model_codes[i]), 32'(e[i]));
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("valid", 32'(valid), 32'(exp_valid));
      chk("code", 32'(code), 32'(exp_code));
      if (valid === 1'b1) dut_codes.push_back(int'(code));
    end
  end

  initial begin
    int v[$];
    int e[$];
    reset = 1'b0;
    din   = '0;
    model_reset();
    repeat (2) @(negedge clk);

    v = '{0, -17, -5,
          12, 34, 59, 21, 30, 43, 64, 70, 90, 55, 30, 21, 11,
          -3, -30, -50, -68, -25, -10,
          14, 30, 45, 79, 121, 80, 70, 60, 75, 99, 110, 80, 50, 40, 60, 76, 100, 80, 50, 30, 10,
          -19};
    apply(v);
    e = '{1, 2, 13, 6, 22};
    check_codes("reference", e);

    v = '{1, -1, 1, -1};
    apply(v);
    e = '{1, 1, 1};
    check_codes("alternating", e);

    v = '{-4, 0, 0, -4};
    apply(v);
    e = '{1, 2};
    check_codes("zero", e);

    // Asynchronous reset mid-epoch, away from any clock edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async reset code", 32'(code), 32'd0);
    chk("async reset valid", 32'(valid), 32'd0);
    model_reset();

    v.delete();
    for (int i = 0; i < 70; i++) v.push_back(5);
    v.push_back(-5);
    apply(v);
    e = '{24};
    check_codes("long", e);

    v.delete();
    v.push_back(50);
    for (int i = 0; i < 9; i++) begin
      v.push_back(40);
      v.push_back(40);
      v.push_back(50);
    end
    v.push_back(60);
    v.push_back(70);
    v.push_back(-5);
    apply(v);
    e = '{27};
    check_codes("shape", e);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
